rb: RTL and testbench

RB -- requirements
Module: rb

---
 rtl/rb.sv | 113 +++++++++++
 tb/tb_rb.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rb.sv
// Reads num_words words from RAM and streams their low DATA_W bits downstream.
// First word valid two clocks after start; ren is throttled so the 2-entry FIFO never overflows.
module rb #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [11:0]       num_words,
  output logic [ADDR_W-1:0] r_addr,
  output logic              ren,
  input  logic [31:0]       dataRAM,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  input  logic              ready,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [11:0]       remaining_q, remaining_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic              inflight_q;
  logic [1:0]        cnt_q;
  logic              rd_ptr_q, wr_ptr_q;
  logic [DATA_W-1:0] mem0_q, mem1_q;
  logic              zero_done_q, zero_done_d;

  logic       pop;
  logic       push;
  logic       last_pop;
  logic [2:0] occ;
  logic       unused_hi;

  assign unused_hi = ^dataRAM[31:DATA_W];

  assign valid    = (cnt_q != 2'd0);
  assign pop      = valid & ready;
  assign push     = inflight_q;
  // Occupancy after this cycle's pop, counting the word still on its way back from RAM.
  assign occ      = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign ren      = (state_q == READ) && (remaining_q != 12'd0) && (occ < 3'd2);
  assign last_pop = (state_q == DRAIN) && !inflight_q && (cnt_q == 2'd1) && pop;
  assign done     = zero_done_q | last_pop;
  assign busy     = (state_q != IDLE);
  assign r_addr   = r_addr_q;
  assign data_out = valid ? (rd_ptr_q ? mem1_q : mem0_q) : '0;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    r_addr_d    = r_addr_q;
    zero_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_words != 12'd0) begin
            state_d     = READ;
            remaining_d = num_words;
            r_addr_d    = '0;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (ren) begin
          remaining_d = remaining_q - 12'd1;
          r_addr_d    = r_addr_q + ADDR_W'(4);
          if (remaining_q == 12'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_pop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      r_addr_q    <= '0;
      inflight_q  <= 1'b0;
      cnt_q       <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      mem0_q      <= '0;
      mem1_q      <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      r_addr_q    <= r_addr_d;
      inflight_q  <= ren;
      zero_done_q <= zero_done_d;
      cnt_q       <= cnt_q + {1'b0, push} - {1'b0, pop};
      if (push) begin
        if (wr_ptr_q) mem1_q <= dataRAM[DATA_W-1:0];
        else          mem0_q <= dataRAM[DATA_W-1:0];
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

endmodule

// File: tb/tb_rb.sv
// Directed bench for rb: a RAM model returns {12'hABC, addr*3} one cycle after ren.
module tb_rb;
  logic        clk = 1'b0;
  logic        rst, start, ren, valid, ready, busy, done;
  logic [11:0] num_words;
  logic [12:0] r_addr;
  logic [31:0] dataRAM;
  logic [19:0] data_out;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rb #(.ADDR_W(13), .DATA_W(20)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .r_addr(r_addr), .ren(ren), .dataRAM(dataRAM), .data_out(data_out),
    .valid(valid), .ready(ready), .busy(busy), .done(done)
  );

  // RAM model: latch the request mid-cycle, present data just after the next edge.
  initial begin
    logic        s_ren;
    logic [12:0] s_addr;
    dataRAM = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      s_ren  = ren;
      s_addr = r_addr;
      @(posedge clk);
      #1;
      dataRAM = s_ren ? {12'hABC, 20'(32'(s_addr) * 3)} : 32'hDEAD_BEEF;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic burst(input string tag, input int n, input int rmode, input int restart_at,
                       input int maxcyc, output int first_ren, output int last_ren,
                       output int first_pop, output int last_pop);
    int issued, got, dones, fifo_m, infl_m, c;
    logic prev_stall, pop, fin;
    logic [19:0] prev_dat;
    logic [12:0] ea;
    issued = 0; got = 0; dones = 0; fifo_m = 0; infl_m = 0;
    prev_stall = 1'b0; prev_dat = '0; fin = 1'b0;
    first_ren = -1; last_ren = -1; first_pop = -1; last_pop = -1;
    cyc();
    start = 1'b1; num_words = 12'(n); ready = 1'b1;
    cyc();
    start = 1'b0;
    for (c = 0; c < maxcyc && !fin; c++) begin
      if (c > 0) cyc();
      ready = (rmode == 0) ? 1'b1 : (c % 3 == 0);
      if (c == restart_at) begin start = 1'b1; num_words = 12'd7; end
      else start = 1'b0;
      #2;
      pop = valid && ready;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_valid"}, 32'(valid), 32'(fifo_m != 0));
      if (prev_stall) chk({tag, "_stable"}, 32'(data_out), 32'(prev_dat));
      if (ren) begin
        ea = 13'(issued * 4);
        chk({tag, "_addr"}, 32'(r_addr), 32'(ea));
        chk({tag, "_room"}, 32'(fifo_m + infl_m - int'(pop) < 2), 32'd1);
        if (first_ren < 0) first_ren = c;
        last_ren = c;
        issued++;
      end
      if (pop) begin
        ea = 13'(got * 4);
        chk({tag, "_data"}, 32'(data_out), 32'(ea) * 3);
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        got++;
      end
      if (done) begin
        dones++;
        fin = 1'b1;
        chk({tag, "_done_on_last_pop"}, 32'(pop && got == n), 32'd1);
      end
      prev_stall = valid && !ready;
      prev_dat   = data_out;
      fifo_m    += infl_m - int'(pop);
      infl_m     = int'(ren);
    end
    chk({tag, "_finished"}, 32'(fin), 32'd1);
    chk({tag, "_issued"}, 32'(issued), 32'(n));
    chk({tag, "_words"}, 32'(got), 32'(n));
    chk({tag, "_dones"}, 32'(dones), 32'd1);
    cyc();
    start = 1'b0;
    #2;
    chk({tag, "_done_off"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_valid"}, 32'(valid), 32'd0);
    chk({tag, "_idle_ren"}, 32'(ren), 32'd0);
  endtask

  initial begin
    int fr, lr, fp, lp;
    rst = 1'b1; start = 1'b0; num_words = '0; ready = 1'b0;
    #2 rst = 1'b0;
    #3;
    chk("rst_addr", 32'(r_addr), 32'd0);
    chk("rst_ren", 32'(ren), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    repeat (3) cyc();
    rst = 1'b1;
    cyc();

    // Four words, ready always high: back-to-back reads and pops.
    burst("b4", 4, 0, -1, 40, fr, lr, fp, lp);
    chk("b4_first_ren", 32'(fr), 32'd0);
    chk("b4_last_ren", 32'(lr), 32'd3);
    chk("b4_first_valid", 32'(fp), 32'd2);
    chk("b4_last_pop", 32'(lp), 32'd5);
    chk("b4_end_addr", 32'(r_addr), 32'd16);

    // Five words with downstream stalling two cycles out of three.
    burst("b5", 5, 1, -1, 60, fr, lr, fp, lp);

    // Zero-length request.
    cyc();
    start = 1'b1; num_words = 12'd0;
    #2;
    chk("z_busy0", 32'(busy), 32'd0);
    chk("z_done_early", 32'(done), 32'd0);
    cyc();
    start = 1'b0;
    #2;
    chk("z_done", 32'(done), 32'd1);
    chk("z_busy", 32'(busy), 32'd0);
    chk("z_ren", 32'(ren), 32'd0);
    chk("z_valid", 32'(valid), 32'd0);
    cyc();
    #2;
    chk("z_done_once", 32'(done), 32'd0);

    // Second start in the middle of a 3-word burst.
    burst("b3", 3, 0, 1, 40, fr, lr, fp, lp);

    // Reset in the cycle after the second read of an 8-word burst.
    cyc();
    start = 1'b1; num_words = 12'd8; ready = 1'b1;
    cyc();
    start = 1'b0;
    #2 chk("r8_ren1", 32'(ren), 32'd1);
    cyc();
    #2 chk("r8_ren2", 32'(ren), 32'd1);
    cyc();
    rst = 1'b0;
    #1;
    chk("r8_addr", 32'(r_addr), 32'd0);
    chk("r8_ren", 32'(ren), 32'd0);
    chk("r8_valid", 32'(valid), 32'd0);
    chk("r8_busy", 32'(busy), 32'd0);
    chk("r8_done", 32'(done), 32'd0);
    chk("r8_data", 32'(data_out), 32'd0);
    #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      #2;
      chk("r8_post_valid", 32'(valid), 32'd0);
      chk("r8_post_ren", 32'(ren), 32'd0);
      chk("r8_post_done", 32'(done), 32'd0);
    end

    // Full address-space burst: address wraps back to zero after the last read.
    burst("b2048", 2048, 0, -1, 2100, fr, lr, fp, lp);
    chk("b2048_wrap_addr", 32'(r_addr), 32'd0);
    chk("b2048_last_ren", 32'(lr), 32'd2047);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
